// File: rtl/rate_sequencer.sv
// rate_sequencer: controller for the rate-divider / hex-counter datapath.
// A down-counting divider produces one-cycle ticks. The period changes over
// four speed stages, and TICKS_PER_STAGE ticks are spent in each stage.
// Build option: define RATE_SEQ_LOOP_EN to restart at the first stage after
// stage 3 instead of finishing through DONE.
module rate_sequencer #(
    parameter int PERIOD_W        = 28,
    parameter int PERIOD0         = 4,
    parameter int PERIOD1         = 3,
    parameter int PERIOD2         = 2,
    parameter int PERIOD3         = 1,
    parameter int TICKS_PER_STAGE = 3
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start,
    input  logic [1:0] start_sel,
    input  logic       pause,
    input  logic       abort,
    output logic       tick,
    output logic [3:0] count,
    output logic [1:0] stage,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    localparam logic [3:0] LAST_COUNT = 4'(TICKS_PER_STAGE - 1);

    state_t              state, state_next;
    logic [PERIOD_W-1:0] div, div_next;
    logic [3:0]          count_next;
    logic [1:0]          stage_next;
    logic                tick_next, done_next;
`ifdef RATE_SEQ_LOOP_EN
    logic [1:0]          start_stage, start_stage_next;
`endif

    // Reload value of the divider for a given stage: the period minus one,
    // so that a tick is issued exactly PERIODn cycles apart.
    function automatic logic [PERIOD_W-1:0] reload(input logic [1:0] s);
        case (s)
            2'd0:    reload = PERIOD_W'(PERIOD0 - 1);
            2'd1:    reload = PERIOD_W'(PERIOD1 - 1);
            2'd2:    reload = PERIOD_W'(PERIOD2 - 1);
            default: reload = PERIOD_W'(PERIOD3 - 1);
        endcase
    endfunction

    assign busy = (state == RUN) || (state == PAUSE);

    // State register and all registered outputs, synchronous active-low reset.
    // NOTE: non-blocking assignments here so every register samples the
    // pre-edge values computed by the combinational block.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state       <= IDLE;
            div         <= '0;
            count       <= '0;
            stage       <= '0;
            tick        <= 1'b0;
            done        <= 1'b0;
`ifdef RATE_SEQ_LOOP_EN
            start_stage <= '0;
`endif
        end else begin
            state       <= state_next;
            div         <= div_next;
            count       <= count_next;
            stage       <= stage_next;
            tick        <= tick_next;
            done        <= done_next;
`ifdef RATE_SEQ_LOOP_EN
            start_stage <= start_stage_next;
`endif
        end
    end

    // Next-state and next-register logic; abort beats pause beats start.
    always_comb begin
        // NOTE: every target gets a default first so no path infers a latch;
        // ticks and done are pulses and default low, the rest hold.
        state_next       = state;
        div_next         = div;
        count_next       = count;
        stage_next       = stage;
        tick_next        = 1'b0;
        done_next        = 1'b0;
`ifdef RATE_SEQ_LOOP_EN
        start_stage_next = start_stage;
`endif
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_next       = RUN;
                    stage_next       = start_sel;
                    div_next         = reload(start_sel);
                    count_next       = '0;
`ifdef RATE_SEQ_LOOP_EN
                    start_stage_next = start_sel;
`endif
                end
            end
            RUN: begin
                if (abort) begin
                    state_next = IDLE;
                    div_next   = '0;
                    count_next = '0;
                    stage_next = '0;
                end else if (pause) begin
                    state_next = PAUSE;
                end else if (div != '0) begin
                    div_next = div - 1'b1;
                end else begin
                    tick_next = 1'b1;
                    if (count == LAST_COUNT) begin
                        count_next = '0;
                        if (stage != 2'd3) begin
                            stage_next = stage + 2'd1;
                            div_next   = reload(stage + 2'd1);
                        end else begin
                            done_next = 1'b1;
`ifdef RATE_SEQ_LOOP_EN
                            stage_next = start_stage;
                            div_next   = reload(start_stage);
`else
                            state_next = DONE;
`endif
                        end
                    end else begin
                        count_next = count + 4'd1;
                        div_next   = reload(stage);
                    end
                end
            end
            PAUSE: begin
                if (abort) begin
                    state_next = IDLE;
                    div_next   = '0;
                    count_next = '0;
                    stage_next = '0;
                end else if (!pause) begin
                    state_next = RUN;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_rate_sequencer.sv
// Self-checking bench for rate_sequencer (default parameters 4,3,2,1 / 3 ticks).
// Directed vector table, hand-written corner sequences, then random stimulus
// compared each cycle against an elapsed-cycle reference model.
module tb_rate_sequencer;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       start;
    logic [1:0] start_sel;
    logic       pause;
    logic       abort;
    logic       tick;
    logic [3:0] count;
    logic [1:0] stage;
    logic       busy;
    logic       done;

    int n_pass  = 0;
    int n_total = 0;

    rate_sequencer dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .start_sel (start_sel),
        .pause     (pause),
        .abort     (abort),
        .tick      (tick),
        .count     (count),
        .stage     (stage),
        .busy      (busy),
        .done      (done)
    );

    always #5 clock = ~clock;

    // Packed view of all outputs: {tick, count, stage, busy, done}.
    function automatic logic [8:0] outs();
        return {tick, count, stage, busy, done};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // One clock edge, then settle away from the edge before sampling.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic rn, input logic st, input logic [1:0] sel,
                         input logic pa, input logic ab);
        reset_n = rn; start = st; start_sel = sel; pause = pa; abort = ab;
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        step();
        drive(1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
    endtask

    // ---------------- reference model ----------------
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;
    localparam int TPS = 3;
    int per [4] = '{4, 3, 2, 1};
    int m_mode, m_stage, m_first, m_count, m_elapsed, m_tick, m_done;

    // Advances the model by one edge. The model counts run cycles elapsed
    // since the last tick and ticks when that equals the stage period.
    task automatic model_step(input logic rn, input logic st, input logic [1:0] sel,
                              input logic pa, input logic ab);
        if (!rn) begin
            m_mode = M_IDLE; m_stage = 0; m_first = 0; m_count = 0;
            m_elapsed = 0; m_tick = 0; m_done = 0;
        end else begin
            case (m_mode)
                M_IDLE: begin
                    m_tick = 0; m_done = 0;
                    if (st && !ab) begin
                        m_mode = M_RUN; m_stage = int'(sel); m_first = int'(sel);
                        m_count = 0; m_elapsed = 0;
                    end
                end
                M_RUN: begin
                    m_done = 0; m_tick = 0;
                    if (ab) begin
                        m_mode = M_IDLE; m_stage = 0; m_count = 0; m_elapsed = 0;
                    end else if (pa) begin
                        m_mode = M_PAUSE;
                    end else begin
                        m_elapsed++;
                        if (m_elapsed == per[m_stage]) begin
                            m_tick = 1; m_elapsed = 0; m_count++;
                            if (m_count == TPS) begin
                                m_count = 0;
                                if (m_stage < 3) m_stage++;
                                else begin
                                    m_done = 1;
`ifdef RATE_SEQ_LOOP_EN
                                    m_stage = m_first;
`else
                                    m_mode = M_DONE;
`endif
                                end
                            end
                        end
                    end
                end
                M_PAUSE: begin
                    m_tick = 0; m_done = 0;
                    if (ab) begin
                        m_mode = M_IDLE; m_stage = 0; m_count = 0; m_elapsed = 0;
                    end else if (!pa) begin
                        m_mode = M_RUN;
                    end
                end
                default: begin
                    m_mode = M_IDLE; m_tick = 0; m_done = 0;
                end
            endcase
        end
    endtask

    function automatic logic [8:0] model_outs();
        logic b;
        b = (m_mode == M_RUN) || (m_mode == M_PAUSE);
        return {1'(m_tick), 4'(m_count), 2'(m_stage), b, 1'(m_done)};
    endfunction

    // ---------------- directed vectors ----------------
    typedef struct {
        logic       rn, st;
        logic [1:0] sel;
        logic       pa, ab;
        logic       e_tick;
        logic [3:0] e_count;
        logic [1:0] e_stage;
        logic       e_busy, e_done;
    } vec_t;

    initial begin
        int tick_edges[$];
        int exp_edges [12] = '{4, 8, 12, 15, 18, 21, 23, 25, 27, 28, 29, 30};
        int done_edge;
        int found;
        int done_seen;
`ifndef RATE_SEQ_LOOP_EN
        // Start at stage 2 (period 2, then 1), run to DONE, then IDLE corners.
        vec_t vt [14] = '{
            '{1'b0, 1'b0, 2'd0, 1'b0, 1'b0,  1'b0, 4'd0, 2'd0, 1'b0, 1'b0},
            '{1'b1, 1'b1, 2'd2, 1'b0, 1'b0,  1'b0, 4'd0, 2'd2, 1'b1, 1'b0},
            '{1'b1, 1'b0, 2'd0, 1'b0, 1'b0,  1'b0, 4'd0, 2'd2, 1'b1, 1'b0},
            '{1'b1, 1'b0, 2'd0, 1'b0, 1'b0,  1'b1, 4'd1, 2'd2, 1'b1, 1'b0},
            '{1'b1, 1'b1, 2'd0, 1'b0, 1'b0,  1'b0, 4'd1, 2'd2, 1'b1, 1'b0},
            '{1'b1, 1'b0, 2'd0, 1'b0, 1'b0,  1'b1, 4'd2, 2'd2, 1'b1, 1'b0},
            '{1'b1, 1'b0, 2'd0, 1'b0, 1'b0,  1'b0, 4'd2, 2'd2, 1'b1, 1'b0},
            '{1'b1, 1'b0, 2'd0, 1'b0, 1'b0,  1'b1, 4'd0, 2'd3, 1'b1, 1'b0},
            '{1'b1, 1'b0, 2'd0, 1'b0, 1'b0,  1'b1, 4'd1, 2'd3, 1'b1, 1'b0},
            '{1'b1, 1'b0, 2'd0, 1'b0, 1'b0,  1'b1, 4'd2, 2'd3, 1'b1, 1'b0},
            '{1'b1, 1'b0, 2'd0, 1'b0, 1'b0,  1'b1, 4'd0, 2'd3, 1'b0, 1'b1},
            '{1'b1, 1'b1, 2'd1, 1'b0, 1'b0,  1'b0, 4'd0, 2'd3, 1'b0, 1'b0},
            '{1'b1, 1'b1, 2'd0, 1'b0, 1'b1,  1'b0, 4'd0, 2'd3, 1'b0, 1'b0},
            '{1'b1, 1'b0, 2'd0, 1'b1, 1'b1,  1'b0, 4'd0, 2'd3, 1'b0, 1'b0}
        };
`endif
        drive(1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        #1;

`ifndef RATE_SEQ_LOOP_EN
        for (int i = 0; i < 14; i++) begin
            drive(vt[i].rn, vt[i].st, vt[i].sel, vt[i].pa, vt[i].ab);
            step();
            check($sformatf("vec%0d", i), 32'(outs()),
                  32'({vt[i].e_tick, vt[i].e_count, vt[i].e_stage, vt[i].e_busy, vt[i].e_done}));
        end
`endif

        // Basic run from stage 0: record which edges carry a tick.
        do_reset();
        check("reset_outs", 32'(outs()), 32'd0);
        drive(1'b1, 1'b1, 2'd0, 1'b0, 1'b0);
        step();
        drive(1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
        done_edge = -1;
        for (int e = 1; e <= 30; e++) begin
            step();
            if (tick) tick_edges.push_back(e);
            if (done && done_edge < 0) done_edge = e;
        end
        check("basic_ntick", 32'(tick_edges.size()), 32'd12);
        for (int k = 0; k < 12; k++)
            check($sformatf("basic_tick%0d", k),
                  32'((k < tick_edges.size()) ? tick_edges[k] : -1), 32'(exp_edges[k]));
        check("basic_done_edge", 32'(done_edge), 32'd30);
`ifndef RATE_SEQ_LOOP_EN
        check("basic_busy_at_done", 32'(busy), 32'd0);
        check("basic_stage_at_done", 32'(stage), 32'd3);
        step();
        check("basic_after_done", 32'({busy, done, tick}), 32'd0);
`else
        check("basic_busy_at_done", 32'(busy), 32'd1);
`endif

        // Pause for 5 cycles with div=2 in stage 0.
        do_reset();
        drive(1'b1, 1'b1, 2'd0, 1'b0, 1'b0);
        step();                                  // E0: div=3
        drive(1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
        step();                                  // E1: div=2
        pause = 1'b1;
        found = 0;
        for (int k = 0; k < 5; k++) begin        // E2..E6 sample pause=1
            step();
            if (tick) found++;
            check($sformatf("pause_busy%0d", k), 32'(busy), 32'd1);
        end
        pause = 1'b0;
        for (int k = 0; k < 3; k++) begin        // E7..E9: resume, div 2->1->0
            step();
            if (tick) found++;
        end
        check("pause_no_tick", 32'(found), 32'd0);
        step();                                  // E10: tick
        check("pause_resume_tick", 32'({tick, count, stage}), 32'({1'b1, 4'd1, 2'd0}));

        // Abort in stage 1 with count=2.
        do_reset();
        drive(1'b1, 1'b1, 2'd0, 1'b0, 1'b0);
        step();
        drive(1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
        found = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            step();
            if (stage == 2'd1 && count == 4'd2) found = 1;
        end
        check("abort_reached", 32'(found), 32'd1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_outs", 32'({count, stage, busy, done, tick}), 32'd0);
        done_seen = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (done) done_seen++;
        end
        check("abort_no_done", 32'(done_seen), 32'd0);

        // Reset mid-run.
        do_reset();
        drive(1'b1, 1'b1, 2'd1, 1'b0, 1'b0);
        step();
        drive(1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) step();
        reset_n = 1'b0;
        step();
        check("midrun_reset", 32'(outs()), 32'd0);
        reset_n = 1'b1;

`ifdef RATE_SEQ_LOOP_EN
        // Loop mode from stage 1: done pulses, stage returns to 1, keeps running.
        do_reset();
        drive(1'b1, 1'b1, 2'd1, 1'b0, 1'b0);
        step();
        drive(1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
        found = 0;
        for (int k = 0; k < 60 && !found; k++) begin
            step();
            if (done) found = 1;
        end
        check("loop_done", 32'(found), 32'd1);
        check("loop_at_done", 32'({stage, busy, tick}), 32'({2'd1, 1'b1, 1'b1}));
        step();
        check("loop_gap1", 32'({tick, done, busy}), 32'({1'b0, 1'b0, 1'b1}));
        step();
        check("loop_gap2", 32'(tick), 32'd0);
        step();
        check("loop_next_tick", 32'({tick, stage}), 32'({1'b1, 2'd1}));
`endif

        // Random stimulus against the reference model.
        drive(1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        model_step(1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        step();
        check("rand_reset", 32'(outs()), 32'(model_outs()));
        for (int c = 0; c < 3000; c++) begin
            logic rn, st, pa, ab;
            logic [1:0] sel;
            rn  = ($urandom_range(199, 0) != 0);
            st  = ($urandom_range(3, 0) == 0);
            sel = 2'($urandom_range(3, 0));
            pa  = ($urandom_range(9, 0) == 0);
            ab  = ($urandom_range(99, 0) == 0);
            drive(rn, st, sel, pa, ab);
            model_step(rn, st, sel, pa, ab);
            step();
            check($sformatf("rand_c%0d", c), 32'(outs()), 32'(model_outs()));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
